univ_shiftreg: RTL

Parametrised universal shift register that generalises the team's fixed 4-bit serial-in/parallel-load register. It adds configurable width, four shift modes (shift up, shift down, rotate, arithmetic shift down), serial ports at both ends, and a shift counter with a one-cycle `done` pulse after every WIDTH shifts. It serves as the common serialiser/deserialiser primitive in the datapath.

---
 rtl/univ_shiftreg.sv | 93 +++++++++
 1 files changed

// File: rtl/univ_shiftreg.sv
// univ_shiftreg
//   Parametrised universal shift register used as the common serialiser /
//   deserialiser primitive. Supports parallel load, four shift modes, serial
//   taps at both ends and a shift counter with a one-cycle done pulse after
//   every WIDTH shifts.
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   CW      shift-counter width, derived from WIDTH
//
// Ports
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-high clear
//   load     in   parallel load strobe (wins over ena)
//   data     in   parallel load value
//   ena      in   shift enable
//   mode     in   00 shift up, 01 shift down, 10 rotate up, 11 arith shift down
//   sin_lo   in   serial input into bit 0 (mode 00)
//   sin_hi   in   serial input into bit WIDTH-1 (mode 01)
//   q        out  register contents
//   sout_hi  out  q[WIDTH-1]
//   sout_lo  out  q[0]
//   cnt      out  shifts since last load, clear or wrap
//   done     out  one-cycle pulse when q holds the result of the WIDTH-th shift
module univ_shiftreg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  output logic [WIDTH-1:0] q,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_ASR = 2'b11
  } mode_t;

  // Wrap point is WIDTH-1, not 2**CW-1, so non-power-of-two widths work.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_shift;

  always_comb begin
    q_shift = q;
    unique case (mode_t'(mode))
      MODE_SHL: q_shift = {q[WIDTH-2:0], sin_lo};
      MODE_SHR: q_shift = {sin_hi, q[WIDTH-1:1]};
      MODE_ROL: q_shift = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR: q_shift = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  q_shift = q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      q    <= data;
      cnt  <= '0;
      done <= 1'b0;
    end else if (ena) begin
      q <= q_shift;
      if (cnt == LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign sout_hi = q[WIDTH-1];
  assign sout_lo = q[0];

endmodule
